// File: rtl/s_mem_seq_pkg.sv
// Shared types and constants for the RC4 s_mem sequencer: state codes, bus widths,
// phase encodings and the watchdog limit.
package s_mem_seq_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int WDOG_W  = 16;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE       = 4'd0;
    localparam state_t S_INIT_START = 4'd1;
    localparam state_t S_INIT_WAIT  = 4'd2;
    localparam state_t S_SWAP_START = 4'd3;
    localparam state_t S_SWAP_WAIT  = 4'd4;
    localparam state_t S_DEC_START  = 4'd5;
    localparam state_t S_DEC_WAIT   = 4'd6;
    localparam state_t S_DONE       = 4'd7;
    localparam state_t S_ERROR      = 4'd8;

    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_INIT = 2'd1;
    localparam logic [1:0] PH_SWAP = 2'd2;
    localparam logic [1:0] PH_DEC  = 2'd3;

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 16'd4096;

    // Phase doubles as the grant select of the port mux.
    function automatic logic [1:0] state_phase(input state_t s);
        case (s)
            S_INIT_START, S_INIT_WAIT: return PH_INIT;
            S_SWAP_START, S_SWAP_WAIT: return PH_SWAP;
            S_DEC_START,  S_DEC_WAIT:  return PH_DEC;
            default:                   return PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/s_mem_port_mux.sv
// 3:1 grant mux onto the single s_mem port; an ungranted port drives all zeros so
// no stray write enable reaches the memory.
module s_mem_port_mux
    import s_mem_seq_pkg::*;
(
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] init_address,
    input  logic [DATA_W-1:0] init_data_in,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] swap_address,
    input  logic [DATA_W-1:0] swap_data_in,
    input  logic              swap_wren,
    input  logic [ADDR_W-1:0] dec_address,
    input  logic [DATA_W-1:0] dec_data_in,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              wren
);

    always_comb begin
        address = '0;
        data_in = '0;
        wren    = 1'b0;
        case (sel)
            PH_INIT: begin
                address = init_address;
                data_in = init_data_in;
                wren    = init_wren;
            end
            PH_SWAP: begin
                address = swap_address;
                data_in = swap_data_in;
                wren    = swap_wren;
            end
            PH_DEC: begin
                address = dec_address;
                data_in = dec_data_in;
                wren    = dec_wren;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/s_mem_sequencer.sv
// Sequences one RC4 pass (init -> swap -> decrypt) and grants s_mem to the active client.
// Optional watchdog with ERROR state enabled by defining S_MEM_SEQ_WATCHDOG_EN.
module s_mem_sequencer
    import s_mem_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_flag,
    output logic              done_flag,
    output logic [1:0]        phase,
    output logic              init_start,
    output logic              swap_start,
    output logic              dec_start,
    input  logic              init_done,
    input  logic              swap_done,
    input  logic              dec_done,
    input  logic [ADDR_W-1:0] init_address,
    input  logic [ADDR_W-1:0] swap_address,
    input  logic [ADDR_W-1:0] dec_address,
    input  logic [DATA_W-1:0] init_data_in,
    input  logic [DATA_W-1:0] swap_data_in,
    input  logic [DATA_W-1:0] dec_data_in,
    input  logic              init_wren,
    input  logic              swap_wren,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              wren,
    output logic              error
);

    state_t state;
    state_t state_nxt;
    logic   wdog_hit;

`ifdef S_MEM_SEQ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              in_start;
    logic              in_wait;

    assign in_start = (state == S_INIT_START) || (state == S_SWAP_START) || (state == S_DEC_START);
    assign in_wait  = (state == S_INIT_WAIT)  || (state == S_SWAP_WAIT)  || (state == S_DEC_WAIT);
    // Fires on the last permitted wait cycle so ERROR is entered after WDOG_LIMIT waits.
    assign wdog_hit = in_wait && (wdog_cnt == (WDOG_LIMIT - 16'd1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_cnt <= '0;
        end else if (in_start) begin
            wdog_cnt <= '0;
        end else if (in_wait) begin
            wdog_cnt <= wdog_cnt + 16'd1;
        end
    end

    assign error = (state == S_ERROR);
`else
    assign wdog_hit = 1'b0;
    assign error    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start_flag) state_nxt = S_INIT_START;
            S_INIT_START: state_nxt = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (init_done)     state_nxt = S_SWAP_START;
                else if (wdog_hit) state_nxt = S_ERROR;
            end
            S_SWAP_START: state_nxt = S_SWAP_WAIT;
            S_SWAP_WAIT: begin
                if (swap_done)     state_nxt = S_DEC_START;
                else if (wdog_hit) state_nxt = S_ERROR;
            end
            S_DEC_START:  state_nxt = S_DEC_WAIT;
            S_DEC_WAIT: begin
                if (dec_done)      state_nxt = S_DONE;
                else if (wdog_hit) state_nxt = S_ERROR;
            end
            // A held start_flag parks here; only its release rearms the sequencer.
            S_DONE:       if (!start_flag) state_nxt = S_IDLE;
            S_ERROR:      state_nxt = S_ERROR;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign phase      = state_phase(state);
    assign init_start = (state == S_INIT_START);
    assign swap_start = (state == S_SWAP_START);
    assign dec_start  = (state == S_DEC_START);
    assign done_flag  = (state == S_DONE);

    s_mem_port_mux u_port_mux (
        .sel          (phase),
        .init_address (init_address),
        .init_data_in (init_data_in),
        .init_wren    (init_wren),
        .swap_address (swap_address),
        .swap_data_in (swap_data_in),
        .swap_wren    (swap_wren),
        .dec_address  (dec_address),
        .dec_data_in  (dec_data_in),
        .dec_wren     (dec_wren),
        .address      (address),
        .data_in      (data_in),
        .wren         (wren)
    );

endmodule

// File: tb/tb_s_mem_sequencer.sv
// Self-checking bench for s_mem_sequencer: directed scenarios plus random traffic,
// every cycle compared against a phase-level reference model.
module tb_s_mem_sequencer;

`ifdef S_MEM_SEQ_WATCHDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start_flag;
    logic       done_flag, error, wren;
    logic [1:0] phase;
    logic       init_start, swap_start, dec_start;
    logic       init_done, swap_done, dec_done;
    logic [7:0] init_address, swap_address, dec_address;
    logic [7:0] init_data_in, swap_data_in, dec_data_in;
    logic       init_wren, swap_wren, dec_wren;
    logic [7:0] address, data_in;

    int n_assert = 0;
    int n_fail   = 0;
    int n_init = 0, n_swap = 0, n_dec = 0;
    bit rand_bus = 1'b1;

    // Reference model: which pass (0 idle, 1..3 phase, 4 done, 5 error), first cycle of a phase, wait count.
    int m_stage = 0;
    bit m_first = 1'b0;
    int m_wd    = 0;

    always #5 clk = ~clk;

    s_mem_sequencer dut (
        .clk(clk), .reset(reset), .start_flag(start_flag), .done_flag(done_flag), .phase(phase),
        .init_start(init_start), .swap_start(swap_start), .dec_start(dec_start),
        .init_done(init_done), .swap_done(swap_done), .dec_done(dec_done),
        .init_address(init_address), .swap_address(swap_address), .dec_address(dec_address),
        .init_data_in(init_data_in), .swap_data_in(swap_data_in), .dec_data_in(dec_data_in),
        .init_wren(init_wren), .swap_wren(swap_wren), .dec_wren(dec_wren),
        .address(address), .data_in(data_in), .wren(wren), .error(error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit done_of(input int stage);
        return (stage == 1) ? init_done : (stage == 2) ? swap_done : dec_done;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_stage = 0; m_first = 1'b0; m_wd = 0;
        end else if (m_stage == 0) begin
            if (start_flag) begin m_stage = 1; m_first = 1'b1; end
        end else if (m_stage >= 1 && m_stage <= 3) begin
            if (m_first) begin
                m_first = 1'b0; m_wd = 0;
            end else if (done_of(m_stage)) begin
                m_stage = m_stage + 1;
                m_first = (m_stage <= 3);
            end else begin
                m_wd++;
                if (WDOG_ON && m_wd >= 4096) m_stage = 5;
            end
        end else if (m_stage == 4) begin
            if (!start_flag) m_stage = 0;
        end
    endtask

    task automatic tick();
        logic [7:0] e_addr, e_data;
        logic       e_wren;
        if (rand_bus) begin
            init_address = 8'($urandom); swap_address = 8'($urandom); dec_address = 8'($urandom);
            init_data_in = 8'($urandom); swap_data_in = 8'($urandom); dec_data_in = 8'($urandom);
            init_wren = 1'($urandom); swap_wren = 1'($urandom); dec_wren = 1'($urandom);
        end
        @(posedge clk);
        model_step();
        #1;
        e_addr = 8'h00; e_data = 8'h00; e_wren = 1'b0;
        if (m_stage == 1) begin e_addr = init_address; e_data = init_data_in; e_wren = init_wren; end
        if (m_stage == 2) begin e_addr = swap_address; e_data = swap_data_in; e_wren = swap_wren; end
        if (m_stage == 3) begin e_addr = dec_address;  e_data = dec_data_in;  e_wren = dec_wren;  end
        chk("phase", {6'd0, phase}, (m_stage >= 1 && m_stage <= 3) ? 8'(m_stage) : 8'd0);
        chk("done_flag", {7'd0, done_flag}, {7'd0, m_stage == 4});
        chk("error", {7'd0, error}, {7'd0, m_stage == 5});
        chk("init_start", {7'd0, init_start}, {7'd0, m_first && m_stage == 1});
        chk("swap_start", {7'd0, swap_start}, {7'd0, m_first && m_stage == 2});
        chk("dec_start", {7'd0, dec_start}, {7'd0, m_first && m_stage == 3});
        chk("address", address, e_addr);
        chk("data_in", data_in, e_data);
        chk("wren", {7'd0, wren}, {7'd0, e_wren});
        if (init_start) n_init++;
        if (swap_start) n_swap++;
        if (dec_start)  n_dec++;
    endtask

    initial begin
        reset = 1'b1; start_flag = 1'b0;
        init_done = 1'b0; swap_done = 1'b0; dec_done = 1'b0;
        init_address = '0; swap_address = '0; dec_address = '0;
        init_data_in = '0; swap_data_in = '0; dec_data_in = '0;
        init_wren = 1'b0; swap_wren = 1'b0; dec_wren = 1'b0;

        // Reset state with start_flag asserted during reset
        start_flag = 1'b1;
        repeat (3) tick();
        chk("rst_phase", {6'd0, phase}, 8'd0);
        chk("rst_wren", {7'd0, wren}, 8'd0);
        reset = 1'b0;
        n_init = 0; n_swap = 0; n_dec = 0;

        // Full pass: init_done at 300, swap_done at 1100, dec_done at 1200
        for (int c = 0; c <= 1300; c++) begin
            init_done = (c == 300); swap_done = (c == 1100); dec_done = (c == 1200);
            tick();
            if (c == 0) chk("init_start_after_start", {7'd0, init_start}, 8'd1);
            if (c == 1200) chk("done_after_dec_done", {7'd0, done_flag}, 8'd1);
        end
        init_done = 1'b0; swap_done = 1'b0; dec_done = 1'b0;
        chk("n_init_start", 8'(n_init), 8'd1);
        chk("n_swap_start", 8'(n_swap), 8'd1);
        chk("n_dec_start", 8'(n_dec), 8'd1);

        // Held start_flag in DONE does not retrigger
        n_init = 0;
        repeat (50) tick();
        chk("held_no_restart", 8'(n_init), 8'd0);
        chk("held_done_flag", {7'd0, done_flag}, 8'd1);
        start_flag = 1'b0;
        tick();
        chk("release_idle", {6'd0, phase}, 8'd0);
        chk("release_done_flag", {7'd0, done_flag}, 8'd0);

        // Misplaced done pulses are ignored
        start_flag = 1'b1;
        tick(); tick();
        dec_done = 1'b1; tick(); dec_done = 1'b0;
        chk("dec_done_ignored", {6'd0, phase}, 8'd1);
        init_done = 1'b1; tick(); init_done = 1'b0;
        chk("swap_start_pulse", {7'd0, swap_start}, 8'd1);
        swap_done = 1'b1; tick(); swap_done = 1'b0;
        chk("swap_done_in_start_ignored", {6'd0, phase}, 8'd2);
        chk("no_dec_start", {7'd0, dec_start}, 8'd0);

        // Grant in SWAP_WAIT passes swap client only
        rand_bus = 1'b0;
        swap_address = 8'h49; swap_data_in = 8'hA5; swap_wren = 1'b1;
        init_address = 8'h11; init_data_in = 8'h22; init_wren = 1'b1;
        tick();
        chk("grant_address", address, 8'h49);
        chk("grant_data_in", data_in, 8'hA5);
        chk("grant_wren", {7'd0, wren}, 8'd1);
        rand_bus = 1'b1;
        swap_done = 1'b1; tick(); swap_done = 1'b0;
        chk("swap_done_advances", {7'd0, dec_start}, 8'd1);

        // Reset mid SWAP_WAIT with start held
        reset = 1'b1; tick(); reset = 1'b0;
        tick(); tick();
        init_done = 1'b1; tick(); init_done = 1'b0;
        repeat (5) tick();
        chk("in_swap_wait", {6'd0, phase}, 8'd2);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midreset_idle", {6'd0, phase}, 8'd0);
        chk("midreset_wren", {7'd0, wren}, 8'd0);
        tick();
        chk("restart_init_start", {7'd0, init_start}, 8'd1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            start_flag = ($urandom_range(0, 9) < 8);
            init_done  = ($urandom_range(0, 4) == 0);
            swap_done  = ($urandom_range(0, 4) == 0);
            dec_done   = ($urandom_range(0, 4) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        init_done = 1'b0; swap_done = 1'b0; dec_done = 1'b0;

        // Watchdog: withhold init_done
        reset = 1'b1; start_flag = 1'b1; tick(); reset = 1'b0;
        repeat (4200) tick();
        chk("wdog_error", {7'd0, error}, {7'd0, WDOG_ON});
        reset = 1'b1; tick(); reset = 1'b0;
        chk("wdog_error_cleared", {7'd0, error}, 8'd0);
        start_flag = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
